// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program-counter sequencer and branch resolver.
// One-cycle branches update pc directly; register-indirect jumps fetch
// their target word through a req/ack memory handshake (RUN/MEM_WAIT FSM).
// Optional feature macro: PC_MEM_TIMEOUT_EN (bounded ack wait with sticky err).
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        status0,
  input  logic        status1,
  input  logic        status2,
  input  logic        instr_valid,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic        flag_we,
  input  logic [31:0] rs_value,
  input  logic [31:0] sp_value,
  input  logic [31:0] imm,
  input  logic [25:0] target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc,
  output logic        stall,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        flag_n,
  output logic        flag_z,
  output logic        err
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam logic [2:0] C_NONE  = 3'b000;
  localparam logic [2:0] C_BMN   = 3'b001;
  localparam logic [2:0] C_BRZ   = 3'b010;
  localparam logic [2:0] C_BZ    = 3'b011;
  localparam logic [2:0] C_JMOR  = 3'b100;
  localparam logic [2:0] C_JALM  = 3'b101;
  localparam logic [2:0] C_JSPAL = 3'b110;
  localparam logic [2:0] C_BEQ   = 3'b111;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_req_q, mem_req_d;
  logic        flag_n_q, flag_n_d;
  logic        flag_z_q, flag_z_d;

  logic [2:0]  code_s;
  logic [31:0] pc4_s;
  logic [31:0] br_off_s;
  logic [31:0] pc_run_s;
  logic [31:0] fetch_addr_s;
  logic        issue_s;
  logic        link_s;
  logic        ack_s;
  logic        timeout_s;

  assign code_s   = {status2, status1, status0};
  assign pc4_s    = pc_q + 32'd4;
  assign br_off_s = imm << 2;
  // An ack only counts while a request is actually outstanding.
  assign ack_s    = (state_q == MEM_WAIT) && mem_req_q && mem_ack;

`ifdef PC_MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  assign timeout_s = (state_q == MEM_WAIT) && !ack_s && (wait_cnt_q == (TIMEOUT_LIMIT - 8'd1));

  // Count MEM_WAIT cycles without ack; latch the fault until reset.
  always_comb begin
    wait_cnt_d = 8'd0;
    if ((state_q == MEM_WAIT) && !ack_s && !timeout_s) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = 8'd0;
    end
    err_d = err_q | timeout_s;
  end

  // Timeout counter and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Resolve the current instruction: next pc for one-cycle branches, or a fetch issue.
  always_comb begin
    issue_s      = 1'b0;
    link_s       = 1'b0;
    fetch_addr_s = 32'd0;
    pc_run_s     = pc_q;
    if ((state_q == RUN) && instr_valid) begin
      case (code_s)
        C_NONE:  pc_run_s = pc4_s;
        C_BEQ:   pc_run_s = zero ? (pc4_s + br_off_s) : pc4_s;
        C_BRZ:   pc_run_s = flag_z_q ? rs_value : pc4_s;
        C_BZ:    pc_run_s = flag_z_q ? {pc4_s[31:28], target, 2'b00} : pc4_s;
        C_BMN: begin
          if (flag_n_q) begin
            issue_s      = 1'b1;
            fetch_addr_s = rs_value + imm;
          end else begin
            pc_run_s = pc4_s;
          end
        end
        C_JMOR: begin
          issue_s      = 1'b1;
          fetch_addr_s = rs_value;
        end
        C_JALM: begin
          issue_s      = 1'b1;
          link_s       = 1'b1;
          fetch_addr_s = rs_value + imm;
        end
        C_JSPAL: begin
          issue_s      = 1'b1;
          link_s       = 1'b1;
          fetch_addr_s = sp_value;
        end
        default: pc_run_s = pc4_s;
      endcase
    end else begin
      pc_run_s = pc_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: leave RUN on a fetch issue, return on ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      state_d = issue_s ? MEM_WAIT : RUN;
      MEM_WAIT: state_d = (ack_s || timeout_s) ? RUN : MEM_WAIT;
      default:  state_d = RUN;
    endcase
  end

  // FSM outputs: stall and link pulse are combinational in the issue cycle.
  always_comb begin
    stall     = rst_n && (issue_s || (state_q == MEM_WAIT));
    link_we   = rst_n && link_s;
    link_data = (rst_n && link_s) ? pc4_s : 32'd0;
  end

  // Datapath next-state: pc, fetch request/address and N/Z flags.
  always_comb begin
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if (state_q == RUN) begin
      pc_d = pc_run_s;
      if (issue_s) begin
        mem_req_d  = 1'b1;
        mem_addr_d = fetch_addr_s;
      end else begin
        mem_req_d = 1'b0;
      end
    end else if (ack_s) begin
      pc_d      = mem_rdata & 32'hFFFF_FFFC;
      mem_req_d = 1'b0;
    end else if (timeout_s) begin
      // pc still holds the faulting instruction, so pc4 is its fall-through.
      pc_d      = pc4_s;
      mem_req_d = 1'b0;
    end else begin
      pc_d = pc_q;
    end
    // Flags update in any state; branches above already used the old values.
    if (flag_we) begin
      flag_n_d = alu_result[31];
      flag_z_d = (alu_result == 32'd0);
    end else begin
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      flag_n_q   <= 1'b0;
      flag_z_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      flag_n_q   <= flag_n_d;
      flag_z_q   <= flag_z_d;
    end
  end

  assign pc       = pc_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign flag_n   = flag_n_q;
  assign flag_z   = flag_z_q;

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, memory-ack wait limit; used only with PC_MEM_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports status0, status1, status2  input  1 each  branch-class code {s2,s1,s0} from the control decoder.
REQ-006 SHALL have port instr_valid  input  1  current instruction is valid; upstream holds it stable while stall=1.
REQ-007 SHALL have ports zero  input  1  ALU zero; alu_result  input  32  ALU result; flag_we  input  1  update N/Z flags.
REQ-008 SHALL have ports rs_value, sp_value, imm  input  32 each  register rs, register $sp, sign-extended immediate; target  input  26  pseudo-direct field.
REQ-009 SHALL have ports mem_req  output  1; mem_addr  output  32; mem_rdata  input  32; mem_ack  input  1  target-fetch handshake.
REQ-010 SHALL have ports pc  output  32; stall  output  1; link_we  output  1; link_data  output  32; flag_n, flag_z  output  1 each; err  output  1.

Function
REQ-011 Codes SHALL be: 000 none (PC+4); 111 beq; 001 bmn; 010 brz; 011 bz; 100 jmor; 101 jalm; 110 jspal.
REQ-012 pc4 = pc+4, modulo 2^32 (wrap at 32'hFFFF_FFFC to 0); branch offset = imm<<2, truncated to 32 bits.
REQ-013 Resolution SHALL occur only when instr_valid=1 in state RUN; instr_valid=0 in RUN SHALL hold pc.
REQ-014 beq: pc <= zero ? pc4+(imm<<2) : pc4, one cycle.
REQ-015 brz: pc <= flag_z ? rs_value : pc4, one cycle.
REQ-016 bz: pc <= flag_z ? {pc4[31:28], target, 2'b00} : pc4, one cycle.
REQ-017 bmn: if flag_n, fetch address rs_value+imm; else pc <= pc4 in one cycle.
REQ-018 jmor: fetch address rs_value unconditionally.
REQ-019 jalm: fetch address rs_value+imm; link_we=1, link_data=pc4 in the issue cycle.
REQ-020 jspal: fetch address sp_value; link_we=1, link_data=pc4 in the issue cycle.
REQ-021 FSM states SHALL be RUN and MEM_WAIT; RUN->MEM_WAIT on any fetch issue; MEM_WAIT->RUN on mem_ack=1 (or timeout, REQ-031).
REQ-022 On issue, mem_addr SHALL be registered and mem_req driven high from the next cycle; both held stable until the mem_ack cycle.
REQ-023 mem_rdata SHALL be sampled in the mem_ack cycle; pc <= {mem_rdata[31:2], 2'b00}; mem_req low the following cycle.
REQ-024 mem_ack while mem_req=0 SHALL be ignored.
REQ-025 stall SHALL be 1 combinationally in the issue cycle and throughout MEM_WAIT, and 0 otherwise; latency of a fetch-type branch = 2 + ack-wait cycles.
REQ-026 Flags: on flag_we, flag_n <= alu_result[31], flag_z <= (alu_result==0); branch in the same cycle SHALL use the pre-update flags.
REQ-027 flag_we SHALL be honoured in any state, including MEM_WAIT.
REQ-028 link_we SHALL be a single-cycle pulse, never asserted in MEM_WAIT.

Reset
REQ-029 On rst_n=0, immediately: pc=RESET_PC, state=RUN, mem_req=0, mem_addr=0, stall=0, link_we=0, link_data=0, flag_n=0, flag_z=0, err=0.
REQ-030 Reset during MEM_WAIT SHALL abandon the fetch; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-031 With PC_MEM_TIMEOUT_EN defined: an 8-bit counter counts MEM_WAIT cycles; reaching TIMEOUT_CYCLES without ack SHALL drop mem_req, set pc <= pc4 of the faulting instruction, set err sticky until reset, return to RUN.
REQ-032 Without PC_MEM_TIMEOUT_EN: no counter exists, MEM_WAIT waits indefinitely, err is tied to 0.

Verification
REQ-033 Reset, instr_valid=1, code 000 for 3 cycles -> pc 0, 4, 8, 12; stall=0.
REQ-034 pc=0x100, beq, zero=1, imm=3 -> pc=0x110 next cycle; zero=0 -> pc=0x104.
REQ-035 pc=0x40, flag_we with alu_result=0 prior cycle, brz rs_value=0x2000 -> pc=0x2000; flag_z=0 -> pc=0x44.
REQ-036 pc=0x80, jalm, rs_value=0x300, imm=4 -> link_we pulse with link_data=0x84; mem_addr=0x304; ack after 3 cycles with mem_rdata=0x1237 -> pc=0x1234; stall high 5 cycles.
REQ-037 jspal with sp_value=0xFFC, rst_n pulsed low in MEM_WAIT -> pc=RESET_PC, mem_req=0; late ack ignored.
REQ-038 PC_MEM_TIMEOUT_EN, bmn flag_n=1, no ack -> after 255 MEM_WAIT cycles mem_req=0, err=1, pc=pc4.
